truth_table_capture: RTL and testbench
======================================

# truth_table_capture

Sequential sweep engine that drives all 32 input combinations into an external 5-input combinational function and reads back its output, assembling the function's complete 32-entry truth table. It sits on the read side of the team's 5-input logic-function blocks. It is used in-system and on the bench to recover, or to cross-check, what a SOP or POS implementation actually computes. An optional second input compares two implementations vector by vector.

## Interface
Parameters:
- SETTLE, default 1: extra hold cycles per vector before sampling. Legal range 0..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Synchronous, active-high.
- start  input  1  request a sweep. Accepted only in IDLE.
- x1, x2, x3, x4, x5  output  1 each  drive the function under test. Vector index = {x1,x2,x3,x4,x5}, with x1 as MSB.
- f_in  input  1  output of the primary function under test.
- g_in  input  1  output of the secondary function. Present only with DUAL_COMPARE_EN.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- tt_valid  output  1  tt holds a complete table. Level signal.
- tt  output  32  captured table; bit k = f_in at vector k.
- mismatch  output  1  at least one vector had f_in≠g_in. Present only with DUAL_COMPARE_EN.
- mismatch_cnt  output  6  number of mismatching vectors, 0..32. Present only with DUAL_COMPARE_EN.
- first_mismatch  output  5  lowest mismatching index. Present only with DUAL_COMPARE_EN.

## Operation
- The state machine has three states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP when start=1. On entry: idx←0, hold counter←0, tt←0, tt_valid←0, compare results cleared.
  - SWEEP: x1..x5 = idx. Hold counter counts 0..SETTLE.
    - On the edge where the counter equals SETTLE: tt[idx]←f_in, the counter resets, and idx increments.
    - After the idx=31 sample: → DONE.
  - DONE (one cycle): done=1, tt_valid←1, then → IDLE.
- start is ignored while busy or in DONE. There is no queuing.
- start in IDLE while tt_valid=1 begins a new sweep and drops tt_valid.
- idx is a 5-bit counter. Its wrap from 31 to 0 coincides with the exit to DONE and never produces a 33rd sample.
- x1..x5 = 0 in IDLE and DONE.
- Outputs only change on clk edges. f_in/g_in are sampled only on the capture edge.
- Reset values: x1..x5=0, busy=0, done=0, tt_valid=0, tt=0, mismatch=0, mismatch_cnt=0, first_mismatch=0. State = IDLE.
- Reset asserted mid-sweep aborts immediately and restores all of the reset values above. A partial table is never exposed.
- rst has priority over start in the same cycle.

## Timing
- start sampled at edge E0. Vector k is driven from edge E0+k·(SETTLE+1). It is sampled at edge E0+(k+1)·(SETTLE+1).
- Last sample is at E0+32·(SETTLE+1). done and tt_valid go high after that edge. done lasts one cycle.
- Sweep latency, start edge to done: 32·(SETTLE+1) cycles. That is 64 cycles for SETTLE=1 and 32 cycles for SETTLE=0.
- busy is high from E0+1 through the cycle before done.
- The external function has SETTLE+1 full cycles of combinational settle per vector.

## Configuration
- DUAL_COMPARE_EN defined:
  - g_in, mismatch, mismatch_cnt and first_mismatch exist.
  - At each capture edge where f_in≠g_in: mismatch_cnt increments. On the first such event only, first_mismatch←idx and mismatch←1.
  - Results are valid with tt_valid and held until the next accepted start or reset.
- DUAL_COMPARE_EN undefined:
  - Those ports and their registers are absent.
  - Sweep and capture behaviour is identical.

## Test plan
- f_in tied to x1, SETTLE=1, start pulse. Required: tt=32'hFFFF0000, done exactly 64 cycles after the start edge, tt_valid=1 afterwards.
- f_in tied to x5, SETTLE=0. Required: tt=32'hAAAAAAAA, done 32 cycles after start. A start held high during the sweep is ignored; exactly one done.
- f_in = x1 & ~x2 & x3. Required: tt=32'h00F00000, i.e. bits 20..23 set.
- Assert rst at vector 10 of a sweep. Required: next cycle all outputs equal their reset values. A following start produces a full, correct table.
- DUAL_COMPARE_EN, f_in=x1, g_in=x1 & x2. Required: mismatch=1, mismatch_cnt=8, first_mismatch=16, tt=32'hFFFF0000.
- DUAL_COMPARE_EN, g_in=f_in. Required: mismatch=0, mismatch_cnt=0, first_mismatch=0. Back-to-back sweeps clear the previous results at the accepted start.

Source files
------------

// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps all 32 input vectors through an external 5-input
// combinational function and assembles its truth table in tt (bit k = f_in at
// vector k, vector index = {x1,x2,x3,x4,x5}).
// Optional feature macro: DUAL_COMPARE_EN adds g_in and vector-by-vector
// compare results (mismatch, mismatch_cnt, first_mismatch).
module truth_table_capture #(
  parameter int SETTLE = 1  // extra hold cycles per vector, 0..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  output logic        x4,
  output logic        x5,
  input  logic        f_in,
`ifdef DUAL_COMPARE_EN
  input  logic        g_in,
`endif
  output logic        busy,
  output logic        done,
  output logic        tt_valid,
  output logic [31:0] tt
`ifdef DUAL_COMPARE_EN
  ,
  output logic        mismatch,
  output logic [5:0]  mismatch_cnt,
  output logic [4:0]  first_mismatch
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state;
  logic [4:0] idx;
  logic [3:0] hold;

  // The vector index register drives the function directly. It is 0 in IDLE
  // and DONE because it is cleared on reset and wraps 31 -> 0 on the exit edge.
  assign {x1, x2, x3, x4, x5} = idx;

  // Sweep controller: accepts start in IDLE, steps through the 32 vectors with
  // SETTLE extra hold cycles each, and raises done/tt_valid after the last one.
  always_ff @(posedge clk) begin
    // NOTE: all state here is assigned non-blocking so every register sees the
    // pre-edge values of the others; blocking would chain updates within an edge.
    if (rst) begin
      // NOTE: tt is an ordinary 32-bit register, not a memory, so it is cleared
      // on reset like everything else; a partial table must never survive reset.
      state          <= IDLE;
      idx            <= '0;
      hold           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      tt_valid       <= 1'b0;
      tt             <= '0;
`ifdef DUAL_COMPARE_EN
      mismatch       <= 1'b0;
      mismatch_cnt   <= '0;
      first_mismatch <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state          <= SWEEP;
            idx            <= '0;
            hold           <= '0;
            busy           <= 1'b1;
            tt             <= '0;
            tt_valid       <= 1'b0;
`ifdef DUAL_COMPARE_EN
            mismatch       <= 1'b0;
            mismatch_cnt   <= '0;
            first_mismatch <= '0;
`endif
          end
        end

        SWEEP: begin
          if (hold == SETTLE_C) begin
            // Capture edge: the function has had SETTLE+1 cycles on this vector.
            tt[idx] <= f_in;
            hold    <= '0;
            // NOTE: idx is exactly 5 bits, so 31 + 1 wraps to 0 on the same edge
            // that leaves SWEEP; no 33rd vector is ever driven or sampled.
            idx     <= idx + 5'd1;
`ifdef DUAL_COMPARE_EN
            if (f_in != g_in) begin
              mismatch_cnt <= mismatch_cnt + 6'd1;
              if (!mismatch) begin
                mismatch       <= 1'b1;
                first_mismatch <= idx;
              end
            end
`endif
            if (idx == 5'd31) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              tt_valid <= 1'b1;
            end
          end else begin
            hold <= hold + 4'd1;
          end
        end

        DONE: begin
          // One-cycle completion pulse; start is ignored here.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Testbench for truth_table_capture: two instances (SETTLE=1 and SETTLE=0),
// each driving a bench-side function of its x outputs. A time-based model
// predicts every output on every cycle; directed sweeps pin literal tables.
module tb_truth_table_capture;

  logic        clk = 1'b0;
  logic [1:0]  start;
  logic [1:0]  rst;
  logic [1:0]  x1, x2, x3, x4, x5;
  logic [1:0]  f_in, g_in;
  logic [1:0]  busy, done, tt_valid;
  logic [31:0] tt [2];
`ifdef DUAL_COMPARE_EN
  logic [1:0]  mismatch;
  logic [5:0]  mismatch_cnt [2];
  logic [4:0]  first_mismatch [2];
`endif

  // Function selection per instance (see eval_fn).
  int          fsel [2];
  int          gsel [2];
  logic [31:0] ftbl [2];
  logic [31:0] gtbl [2];

  int n_checks = 0;
  int n_errors = 0;
  int done_seen [2];

  always #5 clk = ~clk;

  // Functions under test, expressed on the vector index v = {x1..x5}.
  function automatic logic eval_fn(input int sel, input logic [31:0] tbl,
                                   input logic [4:0] v);
    case (sel)
      0:       return v[4];                   // x1
      1:       return v[0];                   // x5
      2:       return v[4] & ~v[3] & v[2];    // x1 & ~x2 & x3
      3:       return tbl[v];                 // arbitrary table
      4:       return v[4] & v[3];            // x1 & x2
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] table_of(input int sel, input logic [31:0] tbl);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[k] = eval_fn(sel, tbl, 5'(k));
    return r;
  endfunction

  function automatic logic [31:0] mask_of(input int c);
    if (c >= 32) return '1;
    return (32'd1 << c) - 32'd1;
  endfunction

  function automatic int first_of(input logic [31:0] d);
    for (int k = 0; k < 32; k++) if (d[k]) return k;
    return 0;
  endfunction

  function automatic int per_of(input int i);
    return (i == 0) ? 2 : 1;  // SETTLE + 1
  endfunction

  assign f_in[0] = eval_fn(fsel[0], ftbl[0], {x1[0], x2[0], x3[0], x4[0], x5[0]});
  assign f_in[1] = eval_fn(fsel[1], ftbl[1], {x1[1], x2[1], x3[1], x4[1], x5[1]});
  assign g_in[0] = eval_fn(gsel[0], gtbl[0], {x1[0], x2[0], x3[0], x4[0], x5[0]});
  assign g_in[1] = eval_fn(gsel[1], gtbl[1], {x1[1], x2[1], x3[1], x4[1], x5[1]});

  truth_table_capture #(.SETTLE(1)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .x1(x1[0]), .x2(x2[0]), .x3(x3[0]), .x4(x4[0]), .x5(x5[0]),
    .f_in(f_in[0]),
`ifdef DUAL_COMPARE_EN
    .g_in(g_in[0]),
`endif
    .busy(busy[0]), .done(done[0]), .tt_valid(tt_valid[0]), .tt(tt[0])
`ifdef DUAL_COMPARE_EN
    , .mismatch(mismatch[0]), .mismatch_cnt(mismatch_cnt[0]),
    .first_mismatch(first_mismatch[0])
`endif
  );

  truth_table_capture #(.SETTLE(0)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .x1(x1[1]), .x2(x2[1]), .x3(x3[1]), .x4(x4[1]), .x5(x5[1]),
    .f_in(f_in[1]),
`ifdef DUAL_COMPARE_EN
    .g_in(g_in[1]),
`endif
    .busy(busy[1]), .done(done[1]), .tt_valid(tt_valid[1]), .tt(tt[1])
`ifdef DUAL_COMPARE_EN
    , .mismatch(mismatch[1]), .mismatch_cnt(mismatch_cnt[1]),
    .first_mismatch(first_mismatch[1])
`endif
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_n counts edges since the accepted start edge; everything else follows
  // from the timing rules: vector k held for SETTLE+1 cycles, sampled at the
  // end of its hold, completion after 32*(SETTLE+1) edges.
  logic        armed = 1'b0;
  logic [1:0]  m_run;
  int          m_n   [2];
  int          m_cap [2];
  logic [1:0]  m_valid;
  logic [31:0] m_tbl  [2];
  logic [31:0] m_gtbl [2];

  always @(posedge clk) begin
    if (rst != 2'b00) armed <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_run[i]   <= 1'b0;
        m_n[i]     <= 0;
        m_cap[i]   <= 0;
        m_valid[i] <= 1'b0;
        m_tbl[i]   <= '0;
        m_gtbl[i]  <= '0;
      end else if (m_run[i]) begin
        m_n[i] <= m_n[i] + 1;
        if (m_n[i] + 1 > 32 * per_of(i)) m_run[i] <= 1'b0;
        else m_cap[i] <= (m_n[i] + 1) / per_of(i);
        if (m_n[i] + 1 == 32 * per_of(i)) m_valid[i] <= 1'b1;
      end else if (start[i]) begin
        m_run[i]   <= 1'b1;
        m_n[i]     <= 0;
        m_cap[i]   <= 0;
        m_valid[i] <= 1'b0;
        m_tbl[i]   <= table_of(fsel[i], ftbl[i]);
        m_gtbl[i]  <= table_of(gsel[i], gtbl[i]);
      end
    end
  end

  // Single compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        if (done[i] === 1'b1) done_seen[i]++;
        check($sformatf("u%0d busy", i), 64'(busy[i]),
              64'(m_run[i] && m_n[i] < 32 * per_of(i)));
        check($sformatf("u%0d done", i), 64'(done[i]),
              64'(m_run[i] && m_n[i] == 32 * per_of(i)));
        check($sformatf("u%0d tt_valid", i), 64'(tt_valid[i]), 64'(m_valid[i]));
        check($sformatf("u%0d vector", i),
              64'({x1[i], x2[i], x3[i], x4[i], x5[i]}),
              64'((m_run[i] && m_n[i] < 32 * per_of(i)) ? m_n[i] / per_of(i) : 0));
        check($sformatf("u%0d tt", i), 64'(tt[i]), 64'(m_tbl[i] & mask_of(m_cap[i])));
`ifdef DUAL_COMPARE_EN
        check($sformatf("u%0d mismatch_cnt", i), 64'(mismatch_cnt[i]),
              64'($countones((m_tbl[i] ^ m_gtbl[i]) & mask_of(m_cap[i]))));
        check($sformatf("u%0d mismatch", i), 64'(mismatch[i]),
              64'(((m_tbl[i] ^ m_gtbl[i]) & mask_of(m_cap[i])) != 0));
        check($sformatf("u%0d first_mismatch", i), 64'(first_mismatch[i]),
              64'(first_of((m_tbl[i] ^ m_gtbl[i]) & mask_of(m_cap[i]))));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  // mode 0: one-cycle start pulse; 1: start held through the sweep and the
  // DONE cycle; 2: random start activity during the sweep.
  task automatic run_sweep(input int i, input int mode, output int lat);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);  // accepted start edge E0
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (done[i] === 1'b1) break;
      if (lat > 400) begin
        check($sformatf("u%0d sweep timeout", i), 64'(lat), 64'(32 * per_of(i)));
        break;
      end
      if (mode == 0) start[i] = 1'b0;
      else if (mode == 2) start[i] = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
    end
    if (mode == 1) begin
      @(posedge clk);  // DONE edge with start still high: must be ignored
      @(negedge clk);
    end
    start[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int lat;
  int d0;
  logic [31:0] rtab;

  initial begin
    start   = '0;
    rst     = 2'b11;
    fsel[0] = 0; fsel[1] = 0;
    gsel[0] = 0; gsel[1] = 0;
    ftbl[0] = '0; ftbl[1] = '0;
    gtbl[0] = '0; gtbl[1] = '0;
    done_seen[0] = 0; done_seen[1] = 0;
    repeat (3) @(negedge clk);
    rst = 2'b00;

    // Reset state
    check("reset tt u0", 64'(tt[0]), 64'h0);
    check("reset tt_valid u0", 64'(tt_valid[0]), 64'h0);
    check("reset busy u1", 64'(busy[1]), 64'h0);

    // Pin the model's tables against hand-computed literals.
    check("model table x1", 64'(table_of(0, '0)), 64'hFFFF0000);
    check("model table x5", 64'(table_of(1, '0)), 64'hAAAAAAAA);
    check("model table x1&~x2&x3", 64'(table_of(2, '0)), 64'h00F00000);

    // f = x1, SETTLE=1
    fsel[0] = 0; gsel[0] = 0;
    run_sweep(0, 0, lat);
    check("x1 latency", 64'(lat), 64'd64);
    check("x1 tt", 64'(tt[0]), 64'hFFFF0000);
    idle(1);
    check("x1 tt_valid after", 64'(tt_valid[0]), 64'h1);

    // f = x5, SETTLE=0, start held high: exactly one done
    fsel[1] = 1; gsel[1] = 1;
    d0 = done_seen[1];
    run_sweep(1, 1, lat);
    check("x5 latency", 64'(lat), 64'd32);
    check("x5 tt", 64'(tt[1]), 64'hAAAAAAAA);
    idle(20);
    check("x5 single done", 64'(done_seen[1] - d0), 64'd1);
    check("x5 idle busy", 64'(busy[1]), 64'h0);

    // f = x1 & ~x2 & x3
    fsel[0] = 2; gsel[0] = 2;
    run_sweep(0, 0, lat);
    check("and3 tt", 64'(tt[0]), 64'h00F00000);

    // Reset at vector 10 aborts; a following sweep is complete and correct.
    rtab = $urandom;
    fsel[0] = 3; ftbl[0] = rtab; gsel[0] = 3; gtbl[0] = rtab;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if ({x1[0], x2[0], x3[0], x4[0], x5[0]} == 5'd10) break;
      @(negedge clk);
    end
    check("reached vector 10", 64'({x1[0], x2[0], x3[0], x4[0], x5[0]}), 64'd10);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("abort vector", 64'({x1[0], x2[0], x3[0], x4[0], x5[0]}), 64'h0);
    check("abort busy", 64'(busy[0]), 64'h0);
    check("abort done", 64'(done[0]), 64'h0);
    check("abort tt_valid", 64'(tt_valid[0]), 64'h0);
    check("abort tt", 64'(tt[0]), 64'h0);
`ifdef DUAL_COMPARE_EN
    check("abort mismatch", 64'(mismatch[0]), 64'h0);
    check("abort mismatch_cnt", 64'(mismatch_cnt[0]), 64'h0);
    check("abort first_mismatch", 64'(first_mismatch[0]), 64'h0);
`endif
    run_sweep(0, 0, lat);
    check("post-abort tt", 64'(tt[0]), 64'(rtab));

`ifdef DUAL_COMPARE_EN
    // f = x1, g = x1 & x2
    fsel[0] = 0; gsel[0] = 4;
    run_sweep(0, 0, lat);
    check("dual tt", 64'(tt[0]), 64'hFFFF0000);
    check("dual mismatch", 64'(mismatch[0]), 64'h1);
    check("dual mismatch_cnt", 64'(mismatch_cnt[0]), 64'd8);
    check("dual first_mismatch", 64'(first_mismatch[0]), 64'd16);
    // Back-to-back with g = f: previous results cleared at the accepted start.
    rtab = $urandom;
    fsel[0] = 3; ftbl[0] = rtab; gsel[0] = 3; gtbl[0] = rtab;
    run_sweep(0, 0, lat);
    check("equal mismatch", 64'(mismatch[0]), 64'h0);
    check("equal mismatch_cnt", 64'(mismatch_cnt[0]), 64'h0);
    check("equal first_mismatch", 64'(first_mismatch[0]), 64'h0);
    check("equal tt", 64'(tt[0]), 64'(rtab));
`endif

    // Randomized sweeps on both instances, random start noise, some resets.
    for (int it = 0; it < 8; it++) begin
      int i;
      i = it % 2;
      fsel[i] = 3;
      ftbl[i] = $urandom;
      gsel[i] = 3;
      gtbl[i] = ($urandom_range(0, 2) == 0) ? ftbl[i] : (ftbl[i] ^ (32'd1 << $urandom_range(0, 31)) ^ ($urandom & $urandom));
      run_sweep(i, 2, lat);
      check($sformatf("rand%0d tt", it), 64'(tt[i]), 64'(ftbl[i]));
      idle($urandom_range(0, 4));
      if (it == 5) begin
        // Reset with start asserted in the same cycle: reset wins.
        @(negedge clk); rst[i] = 1'b1; start[i] = 1'b1;
        @(negedge clk); rst[i] = 1'b0; start[i] = 1'b0;
        check("rst over start busy", 64'(busy[i]), 64'h0);
      end
    end

    idle(5);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
